// File: rtl/basediv.sv
// basediv: iterative restoring divider, one quotient bit per cycle, MSB first.
// Signed mode works on magnitudes and fixes signs at the end.
// Optional build macro BASEDIV_DIVZERO_EN adds the div_zero output and a
// one-cycle fast path for zero divisors; without it zero divisors run the
// full iteration sequence and still yield quotient=all ones, remainder=dividend.
module basediv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             is_signed,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
`ifdef BASEDIV_DIVZERO_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic [WIDTH-1:0] a_reg;     // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] b_reg;     // divisor magnitude
  logic [WIDTH:0]   rem_reg;   // partial remainder
  logic [WIDTH-1:0] q_reg;     // quotient bits collected so far
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic             last_iter;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic [WIDTH+1:0] diff;
  logic             q_bit;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign accept    = in_valid && (state == S_IDLE);
  assign last_iter = (state == S_CALC) && (cnt == CNT_W'(WIDTH - 1));

  // Operand magnitudes and one restoring-division step
  always_comb begin
    src1_neg = is_signed & src1[WIDTH-1];
    src2_neg = is_signed & src2[WIDTH-1];
    src1_mag = src1_neg ? (~src1 + WIDTH'(1)) : src1;
    src2_mag = src2_neg ? (~src2 + WIDTH'(1)) : src2;

    // The shifted partial remainder is below 2^(WIDTH+1), so the top bit of
    // diff is a reliable sign for the trial subtraction.
    diff     = {rem_reg, a_reg[WIDTH-1]} - {2'b00, b_reg};
    q_bit    = ~diff[WIDTH+1];
    rem_step = q_bit ? diff[WIDTH:0] : {rem_reg[WIDTH-1:0], a_reg[WIDTH-1]};
    q_step   = {q_reg[WIDTH-2:0], q_bit};

    // Zero divisor: the magnitude remainder is |dividend|, which the sign fix
    // turns back into the dividend; only the quotient needs forcing.
    if (b_reg == '0) begin
      q_fin = '1;
    end else begin
      q_fin = neg_q ? (~q_step + WIDTH'(1)) : q_step;
    end
    r_fin = neg_r ? (~rem_step[WIDTH-1:0] + WIDTH'(1)) : rem_step[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
`ifdef BASEDIV_DIVZERO_EN
          state_nxt = (src2 == '0) ? S_DONE : S_CALC;
`else
          state_nxt = S_CALC;
`endif
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath, handshake flags and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      q_reg     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`ifdef BASEDIV_DIVZERO_EN
      div_zero  <= 1'b0;
`endif
    end else begin
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state_nxt == S_DONE);

      if (accept) begin
        a_reg   <= src1_mag;
        b_reg   <= src2_mag;
        rem_reg <= '0;
        q_reg   <= '0;
        cnt     <= '0;
        neg_q   <= src1_neg ^ src2_neg;
        neg_r   <= src1_neg;
      end else if (state == S_CALC) begin
        a_reg   <= {a_reg[WIDTH-2:0], 1'b0};
        rem_reg <= rem_step;
        q_reg   <= q_step;
        cnt     <= cnt + CNT_W'(1);
      end

      if (last_iter) begin
        quotient  <= q_fin;
        remainder <= r_fin;
`ifdef BASEDIV_DIVZERO_EN
        div_zero  <= 1'b0;
`endif
      end

`ifdef BASEDIV_DIVZERO_EN
      if (accept && (src2 == '0)) begin
        quotient  <= '1;
        remainder <= src1;
        div_zero  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_basediv.sv
// tb_basediv: directed and random checks of basediv against an arithmetic
// reference model (native SV division on sign-extended 64-bit values).
module tb_basediv;

  localparam int unsigned W = 32;
  localparam int unsigned P = W + 2;   // edges between back-to-back acceptances

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         is_signed;
  logic         out_valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
`ifdef BASEDIV_DIVZERO_EN
  logic         div_zero;
`endif

  int           total;
  int           bad;
  logic [W-1:0] prev_q;

  basediv #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .quotient  (quotient),
`ifdef BASEDIV_DIVZERO_EN
    .div_zero  (div_zero),
`endif
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: truncating division, remainder follows the dividend,
  // zero divisor gives all ones / dividend.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic s, output logic [W-1:0] q,
                                  output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // One full operation; called at a falling edge with the divider idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input string tag);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         zero_fast;
    int           k;
    int           exp_k;
    ref_div(a, b, s, eq, er);
    zero_fast = 1'b0;
`ifdef BASEDIV_DIVZERO_EN
    zero_fast = (b == '0);
`endif
    exp_k = zero_fast ? 0 : int'(W);
    check({tag, " ready"}, 32'(in_ready), 32'd1);
    src1 = a; src2 = b; is_signed = s; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Keep offering junk while busy; it must be ignored.
    in_valid  = (out_valid !== 1'b1);
    src1      = $urandom;
    src2      = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    check({tag, " busy"}, 32'(in_ready), 32'd0);
    if (!zero_fast) check({tag, " hold_q"}, quotient, prev_q);
    k = 0;
    while (out_valid !== 1'b1 && k < int'(3 * W)) begin
      @(negedge clk);
      k++;
      in_valid = (out_valid !== 1'b1);
      src1     = $urandom;
      src2     = $urandom;
    end
    in_valid = 1'b0;
    // k counts edges after the acceptance edge up to the one raising out_valid
    check({tag, " latency"}, 32'(k), 32'(exp_k));
    check({tag, " quo"}, quotient, eq);
    check({tag, " rem"}, remainder, er);
`ifdef BASEDIV_DIVZERO_EN
    check({tag, " dz"}, 32'(div_zero), 32'(b == '0));
`endif
    prev_q = eq;
    @(negedge clk);
    check({tag, " pulse"}, 32'(out_valid), 32'd0);
    check({tag, " idle"}, 32'(in_ready), 32'd1);
  endtask

  logic [W-1:0] oa [0:3*P];
  logic [W-1:0] ob [0:3*P];
  logic         os [0:3*P];

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         seen;
    int           sel;

    total = 0; bad = 0; prev_q = '0;
    reset = 1'b1; in_valid = 1'b0; src1 = '0; src2 = '0; is_signed = 1'b0;
    #1;
    check("rst ready", 32'(in_ready), 32'd1);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst quo", quotient, 32'd0);
    check("rst rem", remainder, 32'd0);
`ifdef BASEDIV_DIVZERO_EN
    check("rst dz", 32'(div_zero), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed corner cases
    run_op(32'd100,        32'd7,          1'b0, "u100_7");
    run_op(32'hFFFFFFF9,   32'd2,          1'b1, "s-7_2");
    run_op(32'd7,          32'hFFFFFFFE,   1'b1, "s7_-2");
    run_op(32'h80000000,   32'hFFFFFFFF,   1'b1, "smin_-1");
    run_op(32'h80000000,   32'hFFFFFFFF,   1'b0, "umin_-1");
    run_op(32'd5,          32'd0,          1'b0, "u5_0");
    run_op(32'd5,          32'd0,          1'b1, "s5_0");
    run_op(32'hFFFFFFFB,   32'd0,          1'b1, "s-5_0");
    run_op(32'hFFFFFFFF,   32'd1,          1'b0, "umax_1");
    run_op(32'd3,          32'd10,         1'b0, "u3_10");

    // Random operations
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       rb = '0;
        1:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2:       rb = W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // in_valid held high with operands changing every cycle
    for (int e = 0; e < int'(3 * P); e++) begin
      oa[e] = $urandom;
      ob[e] = $urandom;
      if (ob[e] == '0) ob[e] = 32'd1;
      os[e] = 1'($urandom_range(0, 1));
      src1 = oa[e]; src2 = ob[e]; is_signed = os[e]; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("strm valid e%0d", e), 32'(out_valid), 32'((e % int'(P)) == int'(W)));
      check($sformatf("strm ready e%0d", e), 32'(in_ready), 32'((e % int'(P)) == int'(P - 1)));
      if ((e % int'(P)) == int'(W)) begin
        ref_div(oa[e - int'(W)], ob[e - int'(W)], os[e - int'(W)], eq, er);
        check($sformatf("strm quo e%0d", e), quotient, eq);
        check($sformatf("strm rem e%0d", e), remainder, er);
        prev_q = eq;
      end
    end
    in_valid = 1'b0;

    // Reset ten cycles into a calculation
    run_op(32'd77, 32'd5, 1'b0, "pre_rst");
    src1 = 32'd1000; src2 = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst ready", 32'(in_ready), 32'd1);
    check("midrst valid", 32'(out_valid), 32'd0);
    check("midrst quo", quotient, 32'd0);
    check("midrst rem", remainder, 32'd0);
    prev_q = '0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (2 * W) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("midrst no_result", 32'(seen), 32'd0);

    // Acceptance on the first edge after reset release
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd1234567, 32'd89, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
